uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_if.sv | 17 +
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side stream bundle for uart_rx_ctrl.
//   m_data  : head word of the receive buffer
//   m_last  : head word closes a frame
//   m_valid : head word present
//   m_ready : consumer accepts the head word
// master = buffer side (drives data/last/valid), slave = consumer side.
interface uart_rx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side buffer between a UART receiver and a stream consumer.
// Words are captured on rising edges of rx_ready, queued in a circular
// buffer, and a frame is closed after IDLE_BITS bit-times of line silence
// by flagging the newest buffered word as last (or, if it already left,
// by a one-cycle frame_gap pulse).
//   clock          : sole clock, rising edge
//   reset          : synchronous, active-high
//   rx_data        : word from the receiver
//   rx_ready       : receiver word-valid level (held several cycles)
//   rx_can_receive : registered permit for the receiver's next word
//   m_if           : head-of-buffer stream (data/last/valid out, ready in)
//   frame_gap      : frame ended after its last word was already consumed
//   level          : words currently buffered
//   overrun_count  : dropped words, saturating at 255
module uart_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int IDLE_BITS  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_ready,
  output logic                     rx_can_receive,
  uart_rx_ctrl_if.master           m_if,
  output logic                     frame_gap,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               overrun_count
);

  localparam int AW            = $clog2(DEPTH);
  localparam int LW            = AW + 1;
  localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int IDLE_TICKS    = IDLE_BITS * TICKS_PER_BIT;
  localparam int TW            = $clog2(IDLE_TICKS) + 1;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PERMIT = LW'(DEPTH - 2);
  localparam logic [TW-1:0] TMR_LAST   = TW'(IDLE_TICKS - 1);

  logic             rx_ready_q;
  logic             rx_seen_low;
  logic             push_pend;
  logic [WIDTH-1:0] push_data;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;

  logic [TW-1:0]    timer;
  logic             armed;

  logic             pop;
  logic             push_ok;
  logic             timeout;
  logic             tail_popping;
  logic             mark_last;

  assign m_if.m_valid = (level != '0);
  assign m_if.m_data  = mem_data[rd_ptr];
  assign m_if.m_last  = mem_last[rd_ptr];

  assign pop     = m_if.m_valid && m_if.m_ready;
  assign push_ok = push_pend && ((level != LVL_FULL) || pop);

  // A pending word suppresses the timeout: the word restarts the timer instead.
  assign timeout = armed && !push_pend && (timer == TMR_LAST);

  // In a FIFO the newest word sits at wr_ptr-1 and is buffered whenever the
  // buffer is non-empty; it is leaving this cycle only if it is the sole entry.
  assign tail_popping = pop && (level == LVL_ONE);
  assign mark_last    = timeout && (level != '0) && !tail_popping;

  always_comb begin
    level_next = level;
    if (push_ok && !pop)
      level_next = level + LVL_ONE;
    else if (!push_ok && pop)
      level_next = level - LVL_ONE;
  end

  // Payload storage needs no reset; only valid entries are ever presented.
  always_ff @(posedge clock) begin
    push_data <= rx_data;
    if (!reset && push_ok)
      mem_data[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ready_q     <= 1'b0;
      rx_seen_low    <= 1'b0;
      push_pend      <= 1'b0;
      mem_last       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      rx_can_receive <= 1'b1;
      overrun_count  <= '0;
      timer          <= '0;
      armed          <= 1'b0;
      frame_gap      <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      // The edge register clears on reset, so a level still high afterwards
      // would look like an edge; require a low sample before the first edge.
      if (!rx_ready)
        rx_seen_low <= 1'b1;
      push_pend <= rx_ready && !rx_ready_q && rx_seen_low;

      if (push_ok) begin
        mem_last[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (mark_last)
        mem_last[wr_ptr - PTR_ONE] <= 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;

      level          <= level_next;
      rx_can_receive <= (level_next <= LVL_PERMIT);

      if (push_pend && !push_ok && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'd1;

      // Dropped words still count as line activity.
      if (push_pend) begin
        timer <= '0;
        armed <= 1'b1;
      end else if (timeout) begin
        timer <= '0;
        armed <= 1'b0;
      end else if (armed) begin
        timer <= timer + TW'(1);
      end

      frame_gap <= timeout && !mark_last;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_can_receive;
  logic       frame_gap;
  logic [3:0] level;
  logic [7:0] overrun_count;

  int checks = 0;
  int errors = 0;
  int gap_cnt = 0;

  uart_rx_ctrl_if #(.WIDTH(8)) bus ();

  uart_rx_ctrl #(
    .WIDTH      (8),
    .DEPTH      (8),
    .CLOCK_FREQ (8),
    .BAUD_RATE  (1),
    .IDLE_BITS  (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_can_receive (rx_can_receive),
    .m_if           (bus),
    .frame_gap      (frame_gap),
    .level          (level),
    .overrun_count  (overrun_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Number of cycles frame_gap has been observed high.
  always @(negedge clock) if (frame_gap === 1'b1) gap_cnt++;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; rx_ready = 1'b0; bus.m_ready = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [7:0] b);
    @(negedge clock);
    rx_data = b; rx_ready = 1'b1;
    repeat (10) @(negedge clock);
    rx_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.m_valid); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.m_last); end
    checks++; if (rx_can_receive !== 1'b1) begin errors++; $display("FAIL reset_permit: got %b expected 1", rx_can_receive); end
    checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", overrun_count); end
    checks++; if (frame_gap !== 1'b0) begin errors++; $display("FAIL reset_gap: got %b expected 0", frame_gap); end
  endtask

  task automatic test_in_order();
    logic [7:0] got [4];
    logic [7:0] exp [3];
    int n = 0;
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    do_reset();
    send_word(8'h41); send_word(8'h42); send_word(8'h43);
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL order_level3: got %0d expected 3", level); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_valid === 1'b1) begin
        if (n < 4) got[n] = bus.m_data;
        n++;
      end
      @(negedge clock);
    end
    bus.m_ready = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL order_pops: got %0d expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL order_word%0d: got %h expected %h", i, got[i], exp[i]); end
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL order_level0: got %0d expected 0", level); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    int n = 0;
    do_reset();
    for (int i = 0; i < 6; i++) send_word(8'h80 + 8'(i));
    checks++; if (rx_can_receive !== 1'b1) begin errors++; $display("FAIL ovr_permit6: got %b expected 1", rx_can_receive); end
    send_word(8'h86);
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL ovr_level7: got %0d expected 7", level); end
    checks++; if (rx_can_receive !== 1'b0) begin errors++; $display("FAIL ovr_permit7: got %b expected 0", rx_can_receive); end
    send_word(8'h87);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovr_level8: got %0d expected 8", level); end
    checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL ovr_count0: got %0d expected 0", overrun_count); end
    send_word(8'h88);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovr_level_drop: got %0d expected 8", level); end
    checks++; if (overrun_count !== 8'd1) begin errors++; $display("FAIL ovr_count1: got %0d expected 1", overrun_count); end
    checks++; if (bus.m_data !== 8'h80) begin errors++; $display("FAIL ovr_head: got %h expected 80", bus.m_data); end

    // Full buffer: push edge coinciding with a pop is accepted.
    @(negedge clock); rx_data = 8'h99; rx_ready = 1'b1;
    @(negedge clock); bus.m_ready = 1'b1;
    @(negedge clock); bus.m_ready = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL simul_level: got %0d expected 8", level); end
    checks++; if (overrun_count !== 8'd1) begin errors++; $display("FAIL simul_overrun: got %0d expected 1", overrun_count); end
    checks++; if (bus.m_data !== 8'h81) begin errors++; $display("FAIL simul_head: got %h expected 81", bus.m_data); end
    repeat (8) @(negedge clock);
    rx_ready = 1'b0;
    @(negedge clock);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.m_valid === 1'b1) begin
        exp = (n < 7) ? 8'h81 + 8'(n) : 8'h99;
        checks++;
        if (bus.m_data !== exp) begin errors++; $display("FAIL drain_word%0d: got %h expected %h", n, bus.m_data, exp); end
        n++;
      end
      @(negedge clock);
    end
    bus.m_ready = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL drain_count: got %0d expected 8", n); end
  endtask

  task automatic test_last_mark();
    int base;
    do_reset();
    base = gap_cnt;
    send_word(8'h10);
    repeat (88) @(negedge clock);
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL last_early: got %b expected 0", bus.m_last); end
    repeat (40) @(negedge clock);
    checks++; if (bus.m_last !== 1'b1) begin errors++; $display("FAIL last_set: got %b expected 1", bus.m_last); end
    checks++; if (bus.m_data !== 8'h10) begin errors++; $display("FAIL last_data: got %h expected 10", bus.m_data); end
    checks++; if (gap_cnt - base !== 0) begin errors++; $display("FAIL last_no_gap: got %0d expected 0", gap_cnt - base); end
    bus.m_ready = 1'b1;
    @(negedge clock);
    bus.m_ready = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL last_level: got %0d expected 0", level); end
  endtask

  task automatic test_frame_gap();
    int base;
    do_reset();
    base = gap_cnt;
    bus.m_ready = 1'b1;
    send_word(8'h20);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL gap_popped: got %0d expected 0", level); end
    repeat (140) @(negedge clock);
    checks++; if (gap_cnt - base !== 1) begin errors++; $display("FAIL gap_once: got %0d expected 1", gap_cnt - base); end
    repeat (500) @(negedge clock);
    checks++; if (gap_cnt - base !== 1) begin errors++; $display("FAIL gap_no_second: got %0d expected 1", gap_cnt - base); end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(8'(i));
    @(negedge clock); rx_data = 8'h05; rx_ready = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_level5: got %0d expected 5", level); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level0: got %0d expected 0", level); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.m_valid); end
    checks++; if (rx_can_receive !== 1'b1) begin errors++; $display("FAIL mid_permit: got %b expected 1", rx_can_receive); end
    repeat (10) @(negedge clock);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_held_high: got %0d expected 0", level); end
    rx_ready = 1'b0;
    repeat (2) @(negedge clock);
    rx_data = 8'h55; rx_ready = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL mid_new_level: got %0d expected 1", level); end
    checks++; if (bus.m_data !== 8'h55) begin errors++; $display("FAIL mid_new_data: got %h expected 55", bus.m_data); end
    rx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; bus.m_ready = 1'b0;
    test_reset();
    test_in_order();
    test_overrun();
    test_last_mark();
    test_frame_gap();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
